regfile_mp: RTL and testbench
=============================

# regfile_mp

Parametrised multi-port register file for the CPU datapath, the successor to the fixed 32×16, two-read/one-write register file. It adds configurable width, depth and port counts, registered reads, a hardware clear sweep after reset, and a per-register busy scoreboard that lets decode stall on pending results. It sits between decode (reads, reservations) and writeback (writes).

## Interface
Parameters:
- DATA_W, 16, register width in bits
- DEPTH, 32, number of registers
- ADDR_W, $clog2(DEPTH), address width
- NUM_RD, 2, number of read ports
- NUM_WR, 2, number of write ports
- ZERO_REG, 1, when 1, register 0 reads as zero and ignores writes and reservations

Ports:
- clk  in  1  clock; single clock domain
- rst  in  1  synchronous, active-high reset
- ready  out  1  high when the clear sweep has finished and the file accepts traffic
- rd_addr  in  NUM_RD×ADDR_W  read addresses
- rd_data  out  NUM_RD×DATA_W  registered read data
- wr_en  in  NUM_WR  write enables
- wr_addr  in  NUM_WR×ADDR_W  write addresses
- wr_data  in  NUM_WR×DATA_W  write data
- rsv_en  in  1  reserve (mark busy) one register
- rsv_addr  in  ADDR_W  register to reserve
- busy  out  DEPTH  per-register pending-write flags
- clr_req  in  1  restart the clear sweep while in RUN

## Operation
- FSM states: CLEAR, RUN.
- Reset: state=CLEAR, ptr=0, ready=0, rd_data=0, busy=0.
- CLEAR: each edge writes 0 to entry ptr, then ptr++. On the edge that clears entry DEPTH-1, the FSM goes to RUN and ready goes to 1. While in CLEAR, wr_en and rsv_en are ignored and rd_data is held at 0.
- RUN: a sampled clr_req returns the FSM to CLEAR with ptr=0 and busy=0. In that cycle, clr_req overrides any write or reservation.
- Reads: rd_data[i] takes the array value at rd_addr[i] on each edge. Latency is 1 cycle.
- Writes: entry wr_addr[j] takes wr_data[j] on the edge when wr_en[j]=1.
  - When several ports target the same address in one cycle, the highest-index port wins.
- Scoreboard: rsv_en sets busy[rsv_addr]. A write clears busy[wr_addr].
  - Reservation and write to the same address in the same cycle: the reservation wins and busy stays 1.
- ZERO_REG=1: address 0 reads 0, writes to it are dropped, and busy[0] is constantly 0.
- Addresses ≥ DEPTH (non-power-of-two DEPTH): writes are dropped and reads return 0.

## Timing
- ready rises exactly DEPTH edges after the first edge with rst=0.
- Read: address presented in cycle t, data valid in cycle t+1.
- Write in cycle t is visible to a read issued in cycle t+1 (data appears in cycle t+2). Same-cycle read/write behaviour depends on RF_BYPASS_EN (see Configuration).
- busy updates on the edge and is visible in the next cycle.
- rst asserted mid-sweep or mid-operation: the next edge restores all reset values, regardless of state.

## Configuration
- RF_BYPASS_EN defined: a read whose address matches an active write in the same cycle returns that write data in cycle t+1.
  - Highest-index matching write port wins.
  - ZERO_REG and out-of-range rules still apply.
- RF_BYPASS_EN undefined: a same-cycle read returns the pre-write value. The writer must wait one cycle.

## Structure
- regfile_pkg holds:
  - default constants RF_DATA_W=16, RF_DEPTH=32, RF_NUM_RD=2, RF_NUM_WR=2
  - state typedef rf_state_e {RF_CLEAR, RF_RUN}
- regfile_scoreboard is a sub-module holding the busy vector with set/clear priority. The top level holds the array, FSM, read muxes and bypass.

## Test plan
- Reset with DEPTH=32, then release rst → ready=0 for 31 edges, ready=1 on edge 32; reading every address returns 0x0000.
- Write 0x4001 to r1 in cycle t; read r1 in cycle t+1 → rd_data=0x4001 at t+2. With RF_BYPASS_EN, a read of r1 in cycle t → 0x4001 at t+1; without it → 0x0000.
- Port 0 writes 0x1111 and port 1 writes 0x2222 to r5 in the same cycle → r5 reads 0x2222.
- Reserve r7, then write r7 → busy[7]=1, then 0. Reserve r9 and write r9 in the same cycle → busy[9] stays 1.
- With ZERO_REG=1, write 0xFFFF to r0 and reserve r0 → r0 reads 0, busy[0]=0.
- Assert clr_req in RUN with r3=0xABCD and busy[3]=1 → ready=0, busy=0, r3 reads 0 after the sweep. Assert rst at ptr=10 → ready=0, ptr restarts at 0.

Source files
------------

// File: rtl/regfile_mp_pkg.sv
// Shared constants and FSM state type for the multi-port register file.
package regfile_pkg;

  localparam int RF_DATA_W = 16;
  localparam int RF_DEPTH  = 32;
  localparam int RF_NUM_RD = 2;
  localparam int RF_NUM_WR = 2;

  typedef enum logic [0:0] {
    RF_CLEAR = 1'b0,
    RF_RUN   = 1'b1
  } rf_state_e;

endpackage

// File: rtl/regfile_mp_if.sv
// Decode/writeback-facing bus of the register file: reads, writes, reservations and status.
interface regfile_mp_if
  import regfile_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int DEPTH  = RF_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int NUM_RD = RF_NUM_RD,
  parameter int NUM_WR = RF_NUM_WR
);

  // Handshake: ready is a level, not a per-transfer acknowledge. wr_en[j] and
  // rsv_en act as the valids and take effect on the edge they are sampled,
  // but only while ready is high; in any other cycle they are dropped.
  // Reads have no valid: rd_data always reflects rd_addr of the previous cycle.
  logic                           ready;
  logic [NUM_RD-1:0][ADDR_W-1:0]  rd_addr;
  logic [NUM_RD-1:0][DATA_W-1:0]  rd_data;
  logic [NUM_WR-1:0]              wr_en;
  logic [NUM_WR-1:0][ADDR_W-1:0]  wr_addr;
  logic [NUM_WR-1:0][DATA_W-1:0]  wr_data;
  logic                           rsv_en;
  logic [ADDR_W-1:0]              rsv_addr;
  logic [DEPTH-1:0]               busy;
  logic                           clr_req;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr, clr_req,
    input  ready, rd_data, busy
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr, clr_req,
    output ready, rd_data, busy
  );

endinterface

// File: rtl/regfile_mp_scoreboard.sv
// Per-register busy flags: a reservation sets, a write clears, reservation wins on a tie.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int DEPTH    = RF_DEPTH,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_flush,
  input  logic              i_set_en,
  input  logic [ADDR_W-1:0] i_set_addr,
  input  logic [DEPTH-1:0]  i_clr_mask,
  output logic [DEPTH-1:0]  o_busy
);

  logic [DEPTH-1:0] r_busy;
  logic [DEPTH-1:0] w_set_mask;

  always_comb begin
    w_set_mask = '0;
    if (i_set_en) w_set_mask[i_set_addr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_busy <= '0;
    end else begin
      r_busy <= (r_busy & ~i_clr_mask) | w_set_mask;
      if (ZERO_REG != 0) r_busy[0] <= 1'b0;
    end
  end

  assign o_busy = r_busy;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with clear sweep, registered reads and busy scoreboard.
// Optional same-cycle write-to-read forwarding is enabled by defining RF_BYPASS_EN.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int DEPTH    = RF_DEPTH,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int NUM_RD   = RF_NUM_RD,
  parameter int NUM_WR   = RF_NUM_WR,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst,
  regfile_mp_if.slave       bus,
  output rf_state_e         o_dbg_state,
  output logic [ADDR_W-1:0] o_dbg_ptr
);

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;

  logic [0:0]                    r_state;
  logic [ADDR_W-1:0]             r_ptr;
  logic [DATA_W-1:0]             r_mem [DEPTH];
  logic [NUM_RD-1:0][DATA_W-1:0] r_rd_data;
  logic [NUM_RD-1:0][DATA_W-1:0] w_rd_val;
  logic [NUM_WR-1:0]             w_wr_act;
  logic [DEPTH-1:0]              w_wr_mask;
  logic [DEPTH-1:0]              w_busy;
  logic                          w_run;
  logic                          w_flush;
  logic                          w_rsv_act;

  // Addresses past the end and the hardwired zero register are never stored.
  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return (32'(a) < DEPTH) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  assign w_run     = (r_state == ST_RUN);
  assign w_flush   = w_run && bus.clr_req;
  assign w_rsv_act = w_run && !bus.clr_req && bus.rsv_en && addr_ok(bus.rsv_addr);

  always_comb begin
    w_wr_act  = '0;
    w_wr_mask = '0;
    for (int j = 0; j < NUM_WR; j++) begin
      w_wr_act[j] = w_run && !bus.clr_req && bus.wr_en[j] && addr_ok(bus.wr_addr[j]);
      if (w_wr_act[j]) w_wr_mask[bus.wr_addr[j]] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_CLEAR;
      r_ptr   <= '0;
    end else if (r_state == ST_CLEAR) begin
      if (r_ptr == ADDR_W'(DEPTH - 1)) begin
        r_state <= ST_RUN;
        r_ptr   <= '0;
      end else begin
        r_ptr <= r_ptr + 1'b1;
      end
    end else if (bus.clr_req) begin
      r_state <= ST_CLEAR;
      r_ptr   <= '0;
    end
  end

  // Later ports are assigned last, so the highest-index writer wins a collision.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (r_state == ST_CLEAR) begin
        r_mem[r_ptr] <= '0;
      end else begin
        for (int j = 0; j < NUM_WR; j++) begin
          if (w_wr_act[j]) r_mem[bus.wr_addr[j]] <= bus.wr_data[j];
        end
      end
    end
  end

  always_comb begin
    w_rd_val = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      if (addr_ok(bus.rd_addr[i])) begin
        w_rd_val[i] = r_mem[bus.rd_addr[i]];
`ifdef RF_BYPASS_EN
        for (int j = 0; j < NUM_WR; j++) begin
          if (w_wr_act[j] && (bus.wr_addr[j] == bus.rd_addr[i])) w_rd_val[i] = bus.wr_data[j];
        end
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || !w_run) r_rd_data <= '0;
    else               r_rd_data <= w_rd_val;
  end

  regfile_scoreboard #(
    .DEPTH    (DEPTH),
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .i_flush    (w_flush),
    .i_set_en   (w_rsv_act),
    .i_set_addr (bus.rsv_addr),
    .i_clr_mask (w_wr_mask),
    .o_busy     (w_busy)
  );

  assign bus.ready   = w_run;
  assign bus.rd_data = r_rd_data;
  assign bus.busy    = w_busy;
  assign o_dbg_state = rf_state_e'(r_state);
  assign o_dbg_ptr   = r_ptr;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: sweep timing, read/write latency, collisions, scoreboard, clear and reset.
module tb_regfile_mp;
  import regfile_pkg::*;

  localparam int DATA_W = 16;
  localparam int DEPTH  = 32;
  localparam int ADDR_W = 5;
  localparam int NUM_RD = 2;
  localparam int NUM_WR = 2;
`ifdef RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  rf_state_e         dbg_state;
  logic [ADDR_W-1:0] dbg_ptr;

  regfile_mp_if #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD), .NUM_WR(NUM_WR)
  ) bus ();

  regfile_mp #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD), .NUM_WR(NUM_WR),
    .ZERO_REG(1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .o_dbg_state (dbg_state),
    .o_dbg_ptr   (dbg_ptr)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard
  int                n_tests = 0;
  int                n_fail  = 0;
  logic [DATA_W-1:0] exp_q[$];
  logic [DEPTH-1:0]  exp_busy;
  int                n_edges;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.wr_en   = '0;
    bus.rsv_en  = 1'b0;
    bus.clr_req = 1'b0;
  endtask

  task automatic write(input int port, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    bus.wr_en[port]   = 1'b1;
    bus.wr_addr[port] = a;
    bus.wr_data[port] = d;
  endtask

  task automatic reserve(input logic [ADDR_W-1:0] a);
    bus.rsv_en   = 1'b1;
    bus.rsv_addr = a;
  endtask

  // Presents both read addresses for one cycle together with whatever writes are set up.
  task automatic read_pair(input string tag, input logic [ADDR_W-1:0] a0, input logic [ADDR_W-1:0] a1,
                           input logic [DATA_W-1:0] e0, input logic [DATA_W-1:0] e1);
    bus.rd_addr[0] = a0;
    bus.rd_addr[1] = a1;
    exp_q.push_back(e0);
    exp_q.push_back(e1);
    tick();
    idle();
    check({tag, "_p0"}, 64'(bus.rd_data[0]), 64'(exp_q.pop_front()));
    check({tag, "_p1"}, 64'(bus.rd_data[1]), 64'(exp_q.pop_front()));
  endtask

  task automatic wait_ready(input string tag);
    n_edges = 0;
    for (int e = 1; e <= 40; e++) begin
      if (bus.ready) break;
      tick();
      n_edges = e;
    end
    check(tag, 64'(n_edges), 64'(DEPTH));
  endtask

  initial begin
    idle();
    bus.rd_addr  = '0;
    bus.wr_addr  = '0;
    bus.wr_data  = '0;
    bus.rsv_addr = '0;
    exp_busy     = '0;

    tick();
    tick();
    check("rst_ready", 64'(bus.ready), 64'(0));
    check("rst_busy", 64'(bus.busy), 64'(0));
    check("rst_rd", 64'(bus.rd_data), 64'(0));
    check("rst_state", 64'(dbg_state), 64'(RF_CLEAR));
    check("rst_ptr", 64'(dbg_ptr), 64'(0));

    // power-on sweep: ready exactly on the DEPTH-th edge after release
    rst = 1'b0;
    for (int e = 1; e <= DEPTH; e++) begin
      tick();
      if (e < DEPTH) check("sweep_ready_low", 64'(bus.ready), 64'(0));
      else           check("sweep_ready_high", 64'(bus.ready), 64'(1));
    end
    for (int a = 0; a < DEPTH; a += 2) read_pair("init_zero", ADDR_W'(a), ADDR_W'(a + 1), 16'h0000, 16'h0000);

    // write latency and same-cycle read
    write(0, 5'd1, 16'h4001);
    read_pair("r1_same", 5'd1, 5'd0, BYP ? 16'h4001 : 16'h0000, 16'h0000);
    read_pair("r1_next", 5'd1, 5'd1, 16'h4001, 16'h4001);

    // two ports on one address: highest index wins
    write(0, 5'd5, 16'h1111);
    write(1, 5'd5, 16'h2222);
    read_pair("r5_same", 5'd5, 5'd1, BYP ? 16'h2222 : 16'h0000, 16'h4001);
    read_pair("r5_next", 5'd5, 5'd5, 16'h2222, 16'h2222);

    // scoreboard set / clear / tie
    reserve(5'd7);
    tick(); idle();
    exp_busy[7] = 1'b1;
    check("busy_rsv7", 64'(bus.busy), 64'(exp_busy));
    write(0, 5'd7, 16'h0707);
    tick(); idle();
    exp_busy[7] = 1'b0;
    check("busy_wr7", 64'(bus.busy), 64'(exp_busy));
    reserve(5'd9);
    write(1, 5'd9, 16'h0909);
    tick(); idle();
    exp_busy[9] = 1'b1;
    check("busy_tie9", 64'(bus.busy), 64'(exp_busy));
    write(0, 5'd9, 16'h9090);
    tick(); idle();
    exp_busy[9] = 1'b0;
    check("busy_wr9", 64'(bus.busy), 64'(exp_busy));
    read_pair("r7_r9", 5'd7, 5'd9, 16'h0707, 16'h9090);

    // hardwired zero register
    write(1, 5'd0, 16'hFFFF);
    reserve(5'd0);
    read_pair("r0_same", 5'd0, 5'd0, 16'h0000, 16'h0000);
    check("busy_r0", 64'(bus.busy), 64'(exp_busy));
    read_pair("r0_next", 5'd0, 5'd7, 16'h0000, 16'h0707);

    // clr_req in RUN overrides the write and reservation of the same cycle
    write(0, 5'd3, 16'hABCD);
    reserve(5'd3);
    tick(); idle();
    exp_busy[3] = 1'b1;
    check("busy_rsv3", 64'(bus.busy), 64'(exp_busy));
    read_pair("r3", 5'd3, 5'd1, 16'hABCD, 16'h4001);
    bus.clr_req = 1'b1;
    write(1, 5'd4, 16'h5555);
    reserve(5'd4);
    tick(); idle();
    exp_busy = '0;
    check("clr_ready", 64'(bus.ready), 64'(0));
    check("clr_busy", 64'(bus.busy), 64'(exp_busy));
    check("clr_state", 64'(dbg_state), 64'(RF_CLEAR));
    check("clr_ptr", 64'(dbg_ptr), 64'(0));

    // during the sweep: reads held at 0, late writes/reservations dropped
    bus.rd_addr[0] = 5'd1;
    n_edges = 0;
    for (int e = 1; e <= 40; e++) begin
      if (bus.ready) break;
      if (e == 25) begin
        write(0, 5'd20, 16'h7777);
        reserve(5'd20);
      end
      tick(); idle();
      n_edges = e;
      if (e == 1) check("clear_rd_held", 64'(bus.rd_data[0]), 64'(0));
    end
    check("clr_sweep_len", 64'(n_edges), 64'(DEPTH));
    check("clr_busy_after", 64'(bus.busy), 64'(0));
    read_pair("post_clr_a", 5'd3, 5'd20, 16'h0000, 16'h0000);
    read_pair("post_clr_b", 5'd4, 5'd1, 16'h0000, 16'h0000);

    // reset mid-operation
    write(0, 5'd2, 16'h2BAD);
    reserve(5'd12);
    tick(); idle();
    exp_busy[12] = 1'b1;
    check("busy_rsv12", 64'(bus.busy), 64'(exp_busy));
    bus.rd_addr[0] = 5'd2;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_busy = '0;
    check("rstop_rd", 64'(bus.rd_data[0]), 64'(0));
    check("rstop_busy", 64'(bus.busy), 64'(exp_busy));
    check("rstop_ready", 64'(bus.ready), 64'(0));

    // reset mid-sweep at ptr=10
    for (int e = 0; e < 10; e++) tick();
    check("mid_ptr", 64'(dbg_ptr), 64'(10));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_ptr", 64'(dbg_ptr), 64'(0));
    check("midrst_state", 64'(dbg_state), 64'(RF_CLEAR));
    check("midrst_ready", 64'(bus.ready), 64'(0));
    wait_ready("midrst_sweep_len");
    read_pair("post_rst", 5'd2, 5'd5, 16'h0000, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
